// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: S-box, key length codes, Nk/Nr lookup,
// FSM state and word-function select encodings.
package aes_pkg;

    localparam logic [1:0] KL_128  = 2'b00;
    localparam logic [1:0] KL_192  = 2'b01;
    localparam logic [1:0] KL_256  = 2'b10;
    localparam logic [1:0] KL_RSVD = 2'b11;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_OFS = 4'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DRAIN} state_e;
    typedef enum logic [1:0] {KW_XOR, KW_ROT, KW_SUB} kw_sel_e;

    // Entry 0 sits in the top byte, so entry x lives at bit offset 8*(255-x).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return NK_192;
            KL_256:  return NK_256;
            default: return NK_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_scheduler_if.sv
// Request/round-key bundle between a key consumer (master) and the scheduler (slave).
interface aes_key_scheduler_if #(parameter int KEY_W = 256);
    // start is a request pulse honoured only while idle; rk moves on a cycle with
    // rk_valid && rk_ready, and rk/rk_index/rk_valid hold while rk_valid && !rk_ready.
    logic                 start;
    logic [1:0]           key_len;
    logic [KEY_W-1:0]     key;
    logic                 rk_ready;
    logic                 rk_valid;
    logic [127:0]         rk;
    logic [3:0]           rk_index;
    logic                 busy;
    logic                 done;
    logic                 err;
    aes_pkg::state_e      dbg_state;

    modport master (
        output start, key_len, key, rk_ready,
        input  rk_valid, rk, rk_index, busy, done, err, dbg_state
    );

    modport slave (
        input  start, key_len, key, rk_ready,
        output rk_valid, rk, rk_index, busy, done, err, dbg_state
    );
endinterface

// File: rtl/aes_key_word_fn.sv
// Combinational next-word function of the key expansion: returns
// w[i-Nk] ^ f(w[i-1]) where f is identity, SubWord(RotWord)^rcon, or SubWord.
module aes_key_word_fn
    import aes_pkg::*;
(
    input  logic [31:0] i_prev,
    input  logic [31:0] i_old,
    input  logic [7:0]  i_rcon,
    input  kw_sel_e     i_sel,
    output logic [31:0] o_word
);
    logic [31:0] w_rot;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub;

    assign w_rot    = {i_prev[23:0], i_prev[31:24]};
    assign w_sub_in = (i_sel == KW_ROT) ? w_rot : i_prev;
    assign w_sub    = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                       sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};

    always_comb begin
        o_word = i_old ^ i_prev;
        case (i_sel)
            KW_ROT:  o_word = i_old ^ w_sub ^ {i_rcon, 24'h000000};
            KW_SUB:  o_word = i_old ^ w_sub;
            default: o_word = i_old ^ i_prev;
        endcase
    end
endmodule

// File: rtl/aes_key_scheduler.sv
// Iterative AES-128/192/256 key expansion, one word per cycle, emitting one
// 128-bit round key per four words over a valid/ready output with backpressure.
module aes_key_scheduler
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8,
    parameter int KEY_W  = 256
) (
    input  logic              clk,
    input  logic              reset,
    aes_key_scheduler_if.slave bus
);
    state_e              r_state;
    state_e              w_next_state;
    logic [KEY_W-1:0]    r_key;
    logic [3:0]          r_nk;
    logic [3:0]          r_nr;
    logic [5:0]          r_i;
    logic [3:0]          r_kpos;
    logic [7:0]          r_rcon;
    logic [31:0]         r_win [MAX_NK];
    logic [31:0]         r_asm0, r_asm1, r_asm2;
    logic [127:0]        r_rk;
    logic [3:0]          r_rk_index;
    logic                r_rk_valid;
    logic                r_err;

    logic [31:0]         w_key_words [MAX_NK];
    logic [31:0]         w_fn_word;
    logic [31:0]         w_new;
    kw_sel_e             w_sel;
    logic                w_from_key, w_hs, w_group_end, w_stall, w_gen, w_last_word;
    logic                w_start_idle, w_accept, w_busy;

    assign w_start_idle = (r_state == ST_IDLE) && bus.start;
    assign w_accept     = w_start_idle && (bus.key_len != KL_RSVD);
    assign w_hs         = r_rk_valid && bus.rk_ready;
    assign w_group_end  = (r_i[1:0] == 2'b11);
    // Only a word that would overwrite an unconsumed round key has to wait.
    assign w_stall      = r_rk_valid && !bus.rk_ready && w_group_end;
    assign w_gen        = (r_state == ST_EXPAND) && !w_stall;
    assign w_last_word  = (r_i == {r_nr, 2'b11});
    assign w_from_key   = (r_i < {2'b00, r_nk});

    always_comb begin
        for (int k = 0; k < MAX_NK; k++) begin
            w_key_words[k] = r_key[KEY_W-1-32*k -: 32];
        end
    end

    always_comb begin
        w_sel = KW_XOR;
        if (!w_from_key) begin
            if (r_kpos == 4'd0) begin
                w_sel = KW_ROT;
            end else if ((r_nk == NK_256) && (r_kpos == 4'd4)) begin
                w_sel = KW_SUB;
            end
        end
    end

    aes_key_word_fn u_word_fn (
        .i_prev (r_win[0]),
        .i_old  (r_win[3'(r_nk - 4'd1)]),
        .i_rcon (r_rcon),
        .i_sel  (w_sel),
        .o_word (w_fn_word)
    );

    assign w_new = w_from_key ? w_key_words[r_i[2:0]] : w_fn_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) w_next_state = ST_EXPAND;
            end
            ST_EXPAND: begin
                if (w_gen && w_last_word) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_hs) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key      <= '0;
            r_nk       <= '0;
            r_nr       <= '0;
            r_i        <= '0;
            r_kpos     <= '0;
            r_rcon     <= 8'h01;
            for (int k = 0; k < MAX_NK; k++) r_win[k] <= '0;
            r_asm0     <= '0;
            r_asm1     <= '0;
            r_asm2     <= '0;
            r_rk       <= '0;
            r_rk_index <= '0;
            r_rk_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_start_idle && (bus.key_len == KL_RSVD);
            if (w_accept) begin
                r_key  <= bus.key;
                r_nk   <= nk_of(bus.key_len);
                r_nr   <= nk_of(bus.key_len) + NR_OFS;
                r_i    <= '0;
                r_kpos <= '0;
                r_rcon <= 8'h01;
            end
            if (w_gen) begin
                r_i    <= r_i + 6'd1;
                r_kpos <= (r_kpos == r_nk - 4'd1) ? 4'd0 : r_kpos + 4'd1;
                if (w_sel == KW_ROT) r_rcon <= xtime(r_rcon);
                r_win[0] <= w_new;
                for (int k = 1; k < MAX_NK; k++) r_win[k] <= r_win[k-1];
                case (r_i[1:0])
                    2'd0:    r_asm0 <= w_new;
                    2'd1:    r_asm1 <= w_new;
                    2'd2:    r_asm2 <= w_new;
                    default: ;
                endcase
            end
            if (w_gen && w_group_end) begin
                r_rk       <= {r_asm0, r_asm1, r_asm2, w_new};
                r_rk_index <= r_i[5:2];
                r_rk_valid <= 1'b1;
            end else if (w_hs) begin
                r_rk_valid <= 1'b0;
            end
        end
    end

    assign bus.rk_valid  = r_rk_valid;
    assign bus.rk        = r_rk;
    assign bus.rk_index  = r_rk_index;
    assign bus.busy      = w_busy;
    assign bus.done      = w_hs && (r_state == ST_DRAIN) && !reset;
    assign bus.err       = r_err;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed bench for aes_key_scheduler using the FIPS-197 key expansion vectors.
module tb_aes_key_scheduler;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    aes_key_scheduler_if #(.KEY_W(256)) bus ();

    aes_key_scheduler #(.MAX_NK(8), .KEY_W(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff_ffffffff};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] got_rk [16];
    int n_keys, n_done, done_cyc, first_cyc, order_err, stall_err;

    task automatic start_exp(input logic [1:0] kl, input logic [255:0] k);
        @(negedge clk);
        bus.start = 1'b1; bus.key_len = kl; bus.key = k;
        @(negedge clk);
        bus.start = 1'b0; bus.key = ~k; bus.key_len = KL_RSVD;
    endtask

    // Runs from the first negedge after the start edge (cycle 0) until a few
    // cycles past done or the cycle budget, recording every handshaken key.
    task automatic collect(input int pct, input int poke_cyc, input int max_cyc);
        logic stalled;
        logic [127:0] h_rk;
        logic [3:0] h_idx;
        int tail;
        n_keys = 0; n_done = 0; done_cyc = -1; first_cyc = -1;
        order_err = 0; stall_err = 0; stalled = 1'b0; tail = -1;
        h_rk = '0; h_idx = '0;
        for (int k = 0; k < 16; k++) got_rk[k] = '0;
        for (int cyc = 0; cyc < max_cyc && tail != 0; cyc++) begin
            bus.rk_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
            bus.start = (cyc == poke_cyc);
            if (cyc == poke_cyc) begin
                bus.key_len = KL_128;
                bus.key = ~bus.key;
            end
            #1;
            if (stalled && (bus.rk !== h_rk || bus.rk_index !== h_idx || bus.rk_valid !== 1'b1)) stall_err++;
            if (bus.done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
                if (tail < 0) tail = 4;
            end
            if (bus.rk_valid === 1'b1 && bus.rk_ready === 1'b1) begin
                if (n_keys < 16) got_rk[n_keys] = bus.rk;
                if (bus.rk_index !== 4'(n_keys)) order_err++;
                if (n_keys == 0) first_cyc = cyc;
                n_keys++;
            end
            stalled = bus.rk_valid && !bus.rk_ready;
            h_rk = bus.rk;
            h_idx = bus.rk_index;
            if (tail > 0) tail--;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.rk_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.rk_valid !== 1'b0) begin failures++; $display("FAIL reset_rk_valid got=%b exp=0", bus.rk_valid); end
        checks++; if (bus.rk !== 128'h0) begin failures++; $display("FAIL reset_rk got=%h exp=0", bus.rk); end
        checks++; if (bus.rk_index !== 4'd0) begin failures++; $display("FAIL reset_rk_index got=%0d exp=0", bus.rk_index); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        reset = 1'b0;
    endtask

    task automatic test_aes128;
        start_exp(KL_128, KEY128);
        collect(100, -1, 200);
        checks++; if (first_cyc !== 4) begin failures++; $display("FAIL a128_first_latency got=%0d exp=4", first_cyc); end
        checks++; if (got_rk[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin failures++; $display("FAIL a128_rk0 got=%h exp=2b7e151628aed2a6abf7158809cf4f3c", got_rk[0]); end
        checks++; if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin failures++; $display("FAIL a128_rk1 got=%h exp=a0fafe1788542cb123a339392a6c7605", got_rk[1]); end
        checks++; if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL a128_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]); end
        checks++; if (n_keys !== 11) begin failures++; $display("FAIL a128_nkeys got=%0d exp=11", n_keys); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL a128_done_count got=%0d exp=1", n_done); end
        checks++; if (done_cyc !== 44) begin failures++; $display("FAIL a128_done_cycle got=%0d exp=44", done_cyc); end
        checks++; if (order_err !== 0) begin failures++; $display("FAIL a128_index_order got=%0d exp=0", order_err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL a128_idle_after got=%b exp=0", bus.busy); end
    endtask

    task automatic test_aes192_start_while_busy;
        start_exp(KL_192, KEY192);
        collect(100, 10, 200);
        checks++; if (got_rk[0] !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin failures++; $display("FAIL a192_rk0 got=%h exp=8e73b0f7da0e6452c810f32b809079e5", got_rk[0]); end
        checks++; if (got_rk[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin failures++; $display("FAIL a192_rk1 got=%h exp=62f8ead2522c6b7bfe0c91f72402f5a5", got_rk[1]); end
        checks++; if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) begin failures++; $display("FAIL a192_rk12 got=%h exp=e98ba06f448c773c8ecc720401002202", got_rk[12]); end
        checks++; if (n_keys !== 13) begin failures++; $display("FAIL a192_nkeys got=%0d exp=13", n_keys); end
        checks++; if (done_cyc !== 52) begin failures++; $display("FAIL a192_done_cycle got=%0d exp=52", done_cyc); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL a192_done_count got=%0d exp=1", n_done); end
        checks++; if (order_err !== 0) begin failures++; $display("FAIL a192_index_order got=%0d exp=0", order_err); end
    endtask

    task automatic test_aes256;
        start_exp(KL_256, KEY256);
        collect(100, -1, 200);
        checks++; if (got_rk[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin failures++; $display("FAIL a256_rk2 got=%h exp=9ba354118e6925afa51a8b5f2067fcde", got_rk[2]); end
        checks++; if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin failures++; $display("FAIL a256_rk14 got=%h exp=fe4890d1e6188d0b046df344706c631e", got_rk[14]); end
        checks++; if (done_cyc !== 60) begin failures++; $display("FAIL a256_done_cycle got=%0d exp=60", done_cyc); end
        checks++; if (n_keys !== 15) begin failures++; $display("FAIL a256_nkeys got=%0d exp=15", n_keys); end
    endtask

    task automatic test_backpressure;
        start_exp(KL_256, KEY256);
        collect(30, -1, 1500);
        checks++; if (got_rk[0] !== 128'h603deb1015ca71be2b73aef0857d7781) begin failures++; $display("FAIL bp_rk0 got=%h exp=603deb1015ca71be2b73aef0857d7781", got_rk[0]); end
        checks++; if (got_rk[1] !== 128'h1f352c073b6108d72d9810a30914dff4) begin failures++; $display("FAIL bp_rk1 got=%h exp=1f352c073b6108d72d9810a30914dff4", got_rk[1]); end
        checks++; if (got_rk[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin failures++; $display("FAIL bp_rk2 got=%h exp=9ba354118e6925afa51a8b5f2067fcde", got_rk[2]); end
        checks++; if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin failures++; $display("FAIL bp_rk14 got=%h exp=fe4890d1e6188d0b046df344706c631e", got_rk[14]); end
        checks++; if (n_keys !== 15) begin failures++; $display("FAIL bp_nkeys got=%0d exp=15", n_keys); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", n_done); end
        checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stable_while_stalled got=%0d exp=0", stall_err); end
        checks++; if (order_err !== 0) begin failures++; $display("FAIL bp_index_order got=%0d exp=0", order_err); end
    endtask

    task automatic test_err;
        @(negedge clk);
        bus.start = 1'b1; bus.key_len = KL_RSVD; bus.key = KEY128;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL err_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.rk_valid !== 1'b0) begin failures++; $display("FAIL err_rk_valid got=%b exp=0", bus.rk_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL err_stay_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_expand;
        bus.rk_ready = 1'b1;
        start_exp(KL_192, KEY192);
        repeat (20) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.rk_valid !== 1'b0) begin failures++; $display("FAIL mid_rk_valid got=%b exp=0", bus.rk_valid); end
        checks++; if (bus.rk !== 128'h0) begin failures++; $display("FAIL mid_rk got=%h exp=0", bus.rk); end
        checks++; if (bus.rk_index !== 4'd0) begin failures++; $display("FAIL mid_rk_index got=%0d exp=0", bus.rk_index); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", bus.err); end
        reset = 1'b0;
        start_exp(KL_128, KEY128);
        collect(100, -1, 200);
        checks++; if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL restart_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]); end
        checks++; if (done_cyc !== 44) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=44", done_cyc); end
        checks++; if (n_keys !== 11) begin failures++; $display("FAIL restart_nkeys got=%0d exp=11", n_keys); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key_len = KL_128;
        bus.key = '0;
        bus.rk_ready = 1'b1;
        test_reset();
        test_aes128();
        test_aes192_start_while_busy();
        test_aes256();
        test_backpressure();
        test_err();
        test_reset_mid_expand();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 Parameter MAX_NK, default 8, meaning the largest supported key length in 32-bit words; the value is fixed at 8 and no other value is supported.
REQ-002 Parameter KEY_W, default 256, meaning the key bus width; KEY_W SHALL equal 32*MAX_NK.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  requests an expansion; sampled only in IDLE.
REQ-006 key_len  input  2  2'b00=AES-128, 2'b01=AES-192, 2'b10=AES-256, 2'b11=reserved.
REQ-007 key  input  KEY_W  cipher key, left-justified: word0=key[255:224]; unused low words are ignored.
REQ-008 rk_ready  input  1  consumer accepts rk this cycle.
REQ-009 rk_valid  output  1  rk holds a valid round key.
REQ-010 rk  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in bits [127:96].
REQ-011 rk_index  output  4  round number r of rk, 0..Nr.
REQ-012 busy  output  1  high in every non-IDLE state.
REQ-013 done  output  1  one-cycle pulse on the handshake of the final round key.
REQ-014 err  output  1  one-cycle pulse when start is seen in IDLE with key_len=2'b11.

Function
REQ-015 Nk = 4, 6 or 8 and Nr = Nk+6; both SHALL be latched with key when start is accepted; later changes on key_len or key have no effect.
REQ-016 States: IDLE, EXPAND, DRAIN. IDLE->EXPAND on start with a legal key_len. EXPAND->DRAIN after word 4*Nr+3 is produced. DRAIN->IDLE on the final rk handshake.
REQ-017 In EXPAND, one word w[i] SHALL be produced per cycle, starting at i=0.
REQ-018 For i<Nk, w[i] = key word i.
REQ-019 For i%Nk==0, w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}.
REQ-020 For Nk==8 and i%Nk==4, w[i] = w[i-Nk] ^ SubWord(w[i-1]).
REQ-021 For all other i >= Nk, w[i] = w[i-Nk] ^ w[i-1].
REQ-022 Previous words SHALL be held in an 8-deep word window plus a 3-word assembly register; a full schedule array is not allowed.
REQ-023 rcon SHALL reset to 8'h01 at start and advance by GF(2^8) doubling (xtime, reduction 8'h1b) after each use.
REQ-024 On the edge producing w[4r+3], rk, rk_index and rk_valid SHALL load r, the three assembly words and the new word, and 1.
REQ-025 With rk_ready held high, round key 0 becomes valid 4 cycles after the start edge, and the final key becomes valid 4*(Nr+1) cycles after it (44/52/60).
REQ-026 Backpressure: when rk_valid=1, rk_ready=0 and the next word would complete a group, word generation SHALL stall and all state SHALL hold.
REQ-027 A handshake and a new group completion in the same cycle SHALL reload rk without a bubble.
REQ-028 rk, rk_index and rk_valid SHALL stay stable while rk_valid=1 and rk_ready=0.
REQ-029 A non-final handshake clears rk_valid unless REQ-027 applies.
REQ-030 start while busy SHALL be ignored.
REQ-031 start with key_len=2'b11 SHALL pulse err, stay in IDLE and leave outputs unchanged.

Reset
REQ-032 reset SHALL take priority over every other input, including during EXPAND or a stall.
REQ-033 On reset: state=IDLE; rk_valid, rk, rk_index, busy, done and err = 0; the window is cleared; rcon = 8'h01.

Structure
REQ-034 Shared package aes_pkg SHALL hold the S-box table, the key_len codes, and the Nk/Nr lookup constants.
REQ-035 Sub-module aes_key_word_fn SHALL implement RotWord, SubWord (4 S-boxes), the rcon XOR and the Nk==8 SubWord-only path as pure combinational logic.
REQ-036 aes_key_scheduler SHALL hold the FSM, counters, window and output register.

Verification
REQ-037 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> 11 keys; rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done 44 cycles after start.
REQ-038 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_index 12 = e98ba06f448c773c8ecc720401002202; 13 keys total.
REQ-039 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_index 14 = fe4890d1e6188d0b046df344706c631e.
REQ-040 AES-256 with rk_ready random at 30% -> identical key sequence to REQ-039, rk stable while stalled, exactly one done pulse.
REQ-041 reset asserted at cycle 20 of AES-192 -> all outputs 0 next cycle; immediate AES-128 restart reproduces REQ-037.
REQ-042 start with key_len=2'b11 -> one err pulse, busy stays 0; start pulsed during busy -> sequence unaffected.
